// File: rtl/pixel_unpacker.sv
// pixel_unpacker: splits packed multi-pixel words into a one-pixel-per-cycle
// stream. A single hold register sits in front of an output shift register, so
// the next word is always staged before the current one runs out. A column
// counter flags the final pixel of each image line with m_last.
module pixel_unpacker #(
    parameter int WORD_BYTES = 5,
    parameter int LINE_WIDTH = 640
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [8*WORD_BYTES-1:0]   s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [7:0]                m_data,
    output logic                      m_last,
    output logic                      busy
);

    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int CNT_W  = $clog2(WORD_BYTES + 1);
    localparam int COL_W  = $clog2(LINE_WIDTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);

    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [COL_W-1:0]  col;

    logic in_hs;
    logic out_hs;
    logic reload;

    // Outputs are taken straight from registers; s_ready never sees m_ready.
    assign s_ready = !hold_valid && !rst;
    assign m_valid = (cnt != '0);
    assign m_data  = shreg[7:0];
    assign m_last  = m_valid && (col == COL_LAST);
    assign busy    = hold_valid || (cnt != '0);

    // Handshake and reload decode for the current cycle.
    always_comb begin
        in_hs  = s_valid && s_ready;
        out_hs = m_valid && m_ready;
        // Reload as soon as the shifter is empty, or in the same cycle its
        // last pixel leaves, so back-to-back words stream without a bubble.
        reload = hold_valid && ((cnt == '0) || ((cnt == CNT_ONE) && out_hs));
    end

    // Hold payload: only meaningful while hold_valid is set.
    // NOTE: hold_data is deliberately left out of reset -- hold_valid qualifies
    // it, so clearing the payload would only add reset fan-out for no benefit.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            hold_data <= s_data;
        end
    end

    // Hold flag, shift register, remaining-pixel count and column counter.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
            col        <= '0;
        end else begin
            // in_hs and reload are mutually exclusive: in_hs needs an empty
            // hold register, reload needs a full one.
            if (in_hs) begin
                hold_valid <= 1'b1;
            end

            if (reload) begin
                shreg      <= hold_data;
                cnt        <= CNT_FULL;
                hold_valid <= 1'b0;
            end else if (out_hs) begin
                shreg <= shreg >> 8;
                cnt   <= cnt - CNT_ONE;
            end

            // Line position follows emitted pixels, not word boundaries.
            if (out_hs) begin
                if (col == COL_LAST) begin
                    col <= '0;
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/pixel_unpacker.md
# pixel_unpacker

Unpacks 40-bit pixel words (five 8-bit pixels, oldest pixel in bits [7:0]) back into a one-pixel-per-cycle stream, with valid/ready handshakes on both sides. It is the transmit-side counterpart to the window-packing shift register and feeds pixel-serial consumers such as the display and UART output paths. It sustains one pixel per clock with continuous input. A column counter marks the last pixel of every image line.

## Interface
- WORD_BYTES, 5, pixels per input word; s_data width is 8*WORD_BYTES.
- LINE_WIDTH, 640, pixels per image line; must be ≥ 2.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept a word; equals !hold_valid && !rst.
- s_data  in  8*WORD_BYTES  packed pixels; byte k is bits [8k+7:8k] and is emitted k-th.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts pixel.
- m_data  out  8  current pixel.
- m_last  out  1  m_data is the final pixel of a line (column LINE_WIDTH-1).
- busy  out  1  hold_valid or any pixel still pending.

## Operation
- Two storage stages.
  - Hold register: hold_data, hold_valid.
  - Output shift register: shreg (8*WORD_BYTES bits) with remaining-byte count cnt (0..WORD_BYTES).
- Input handshake is s_valid && s_ready.
  - Captures s_data into hold_data.
  - Sets hold_valid.
- Output handshake is m_valid && m_ready, with m_valid = (cnt != 0) and m_data = shreg[7:0].
  - Shifts shreg right by 8 bits (zero fill).
  - Decrements cnt.
- Reload condition: hold_valid && (cnt == 0 || (cnt == 1 && output handshake)).
  - shreg ← hold_data, cnt ← WORD_BYTES, hold_valid ← 0.
  - Reload takes priority over the shift and decrement in the same cycle.
- The input handshake cannot occur in a reload cycle, because s_ready = 0 whenever hold_valid = 1.
- Column counter col (width clog2(LINE_WIDTH)):
  - Increments on each output handshake.
  - Wraps from LINE_WIDTH-1 to 0.
  - m_last = m_valid && (col == LINE_WIDTH-1).
  - Word boundaries are independent of line boundaries; lines need not be word-aligned.
- Backpressure: while m_ready = 0, m_data, m_last and cnt hold. hold_valid stays 1 once set, so s_ready stays 0.
- Reset (also mid-operation): hold_valid=0, cnt=0, shreg=0, col=0. Any pending pixels and words are discarded.
  - Output values: m_valid=0, m_data=0, m_last=0, s_ready=0 during rst, busy=0.

## Timing
- Latency: input handshake at edge N → hold_valid at N+1. The reload happens on the following edge, so m_valid=1 with byte 0 from after edge N+2.
- Throughput: with s_valid held high and m_ready held high, m_valid stays 1 continuously, with no bubbles between words.
  - This works because s_ready returns 1 the cycle after each reload, four cycles before the hold word is needed.
- Word handoff: the last byte of word A (cnt=1, handshake) is followed on the next cycle by byte 0 of word B, provided hold_valid was 1.
- s_ready is a function of registers and rst only; there is no combinational path from m_ready.
- m_last is asserted coincident with the pixel it marks. col updates only on an output handshake.

## Test plan
- Single word: reset, then one word 0x5544332211 with m_ready=1.
  - m_data sequence 0x11,0x22,0x33,0x44,0x55 starting 2 cycles after acceptance.
  - m_valid then drops; busy then drops.
- Streaming: 4 consecutive words, s_valid and m_ready held high.
  - 20 pixels on 20 consecutive cycles with no m_valid gap.
  - s_ready pulses once per 5 cycles.
- Backpressure: m_ready toggled as 1,0,0,1,… during a 2-word transfer.
  - No pixel is lost or duplicated; order is preserved.
  - m_data is stable while m_ready=0; s_ready stays 0 while hold is full.
- Line marker: LINE_WIDTH=7, stream 3 words (15 pixels).
  - m_last high on pixels 6 and 13 only.
  - col is 1 after pixel 14.
- Reset mid-word: assert rst after the 2nd pixel of a word while hold is full.
  - The next cycle shows m_valid=0, busy=0 and col=0.
  - After reset, a new word 0x0A09080706 emits 0x06 first, with m_last cleared.
- Idle input: s_valid=0 for 10 cycles after a word drains.
  - m_valid stays 0; s_ready stays 1.
  - The next word follows the 2-cycle latency.
